// File: rtl/leaf_loader_pkg.sv
// leaf_loader_pkg
// Shared types and width helpers for the leaf loader and its arbiter.
//   state_e  : loader FSM states
//   elem_w   : width of a 0..LEN_SEQ element counter
//   term_w   : width of a 0..TERM_CNT terminator counter (min 1 bit)
//   idx_w    : width of an index into N items (min 1 bit)
package leaf_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int elem_w(input int len_seq);
        return (len_seq < 1) ? 1 : $clog2(len_seq + 1);
    endfunction

    function automatic int term_w(input int term_cnt);
        return (term_cnt < 1) ? 1 : $clog2(term_cnt + 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/leaf_loader_rr.sv
// rr_arbiter
// N-way round-robin arbiter. The search starts at the pointer; after a
// used grant of k the pointer moves to (k+1) mod N. No grant leaves the
// pointer untouched.
//   clk, rst  : clock, synchronous active-high reset
//   clr       : pointer back to 0
//   en        : grant is consumed this cycle (advance pointer)
//   req[N]    : request vector
//   gnt[N]    : one-hot grant (zero when no request)
//   gnt_idx   : index of the granted requester
//   gnt_vld   : any grant this cycle
module rr_arbiter
    import leaf_loader_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);

    logic [IW-1:0] ptr_q;

    always_comb begin
        int j;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (!gnt_vld && req[j]) begin
                gnt_vld = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr)
            ptr_q <= '0;
        else if (en && gnt_vld)
            ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

endmodule

// File: rtl/leaf_loader.sv
// leaf_loader
// Fills the leaf FIFOs of a merger tree from a sorted-run memory: every
// leaf gets its LEN_SEQ-record run followed by TERM_CNT zero records.
// One leaf is selected per RUN cycle (S1, memory read issued), and its
// FIFO is written the following cycle (S2) with the returned data.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_start          : start pulse, honoured only in IDLE
//   o_busy / o_done  : pass in progress / one-cycle completion pulse
//   o_mem_rd/addr    : memory read, data on i_mem_data one cycle later
//   i_fifo_full      : per-leaf full flags
//   o_fifo_write     : one-hot write strobe, o_fifo_data shared bus
// Optional: LEAF_LOADER_PERF_EN adds o_cycle_cnt / o_stall_cnt.
module leaf_loader
    import leaf_loader_pkg::*;
#(
    parameter int LEAF_CNT   = 256,
    parameter int LEN_SEQ    = 16,
    parameter int TERM_CNT   = 20,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = idx_w(LEAF_CNT * LEN_SEQ)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_rd,
    output logic [ADDR_W-1:0]     o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic [LEAF_CNT-1:0]   i_fifo_full,
    output logic [LEAF_CNT-1:0]   o_fifo_write,
    output logic [DATA_WIDTH-1:0] o_fifo_data
`ifdef LEAF_LOADER_PERF_EN
    ,
    output logic [31:0]           o_cycle_cnt,
    output logic [31:0]           o_stall_cnt
`endif
);

    localparam int EW = elem_w(LEN_SEQ);
    localparam int TW = term_w(TERM_CNT);
    localparam int IW = idx_w(LEAF_CNT);

    state_e state_q, state_d;

    logic [LEAF_CNT-1:0][EW-1:0] elem_q;
    logic [LEAF_CNT-1:0][TW-1:0] term_q;

    logic [LEAF_CNT-1:0] finished, is_elem, last_step, fin_after;
    logic [LEAF_CNT-1:0] req, gnt;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_vld;
    logic                gnt_is_elem;
    logic [EW-1:0]       sel_elem;
    logic                wr_elem_q;
    logic                start_acc;
    logic                run;

    assign run       = (state_q == ST_RUN);
    assign start_acc = i_start && (state_q == ST_IDLE);
    assign o_busy    = (state_q != ST_IDLE);

    // Per-leaf status. last_step flags a leaf whose next grant finishes it,
    // which is what lets RUN hand over to DRAIN on the final selection.
    always_comb begin
        finished  = '0;
        is_elem   = '0;
        last_step = '0;
        fin_after = '0;
        for (int i = 0; i < LEAF_CNT; i++) begin
            is_elem[i]  = (elem_q[i] != EW'(LEN_SEQ));
            finished[i] = !is_elem[i] && (term_q[i] == TW'(TERM_CNT));
            if (TERM_CNT == 0)
                last_step[i] = (elem_q[i] == EW'(LEN_SEQ - 1));
            else
                last_step[i] = !is_elem[i] && (term_q[i] == TW'(TERM_CNT - 1));
            fin_after[i] = finished[i] | (gnt[i] & last_step[i]);
        end
    end

    // o_fifo_write is exactly last cycle's selection, so masking with it
    // keeps at most one write per leaf in flight; that is what makes a
    // full flag sampled low at S1 safe at S2.
    assign req = ~finished & ~i_fifo_full & ~o_fifo_write & {LEAF_CNT{run}};

    rr_arbiter #(.N(LEAF_CNT), .IW(IW)) u_arb (
        .clk     (i_clk),
        .rst     (i_rst),
        .clr     (start_acc),
        .en      (run),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        sel_elem    = '0;
        gnt_is_elem = 1'b0;
        for (int i = 0; i < LEAF_CNT; i++) begin
            if (gnt[i]) begin
                sel_elem    = elem_q[i];
                gnt_is_elem = is_elem[i];
            end
        end
    end

    assign o_mem_rd   = gnt_vld && gnt_is_elem;
    assign o_mem_addr = o_mem_rd ?
        ADDR_W'(int'(gnt_idx) * LEN_SEQ + int'(sel_elem)) : '0;

    // Element first, then terminators; counters restart on every pass.
    always_ff @(posedge i_clk) begin
        if (i_rst || start_acc) begin
            elem_q <= '0;
            term_q <= '0;
        end else begin
            for (int i = 0; i < LEAF_CNT; i++) begin
                if (gnt[i]) begin
                    if (is_elem[i]) elem_q[i] <= elem_q[i] + 1'b1;
                    else            term_q[i] <= term_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (i_start) state_d = ST_RUN;
            ST_RUN:   if (gnt_vld && (&fin_after)) state_d = ST_DRAIN;
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            o_fifo_write <= '0;
            wr_elem_q    <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_fifo_write <= gnt;
            wr_elem_q    <= gnt_is_elem;
            o_done       <= (state_q == ST_DONE);
        end
    end

    // Memory data lands in the S2 cycle, so the bus is a live mux.
    assign o_fifo_data = (|o_fifo_write && wr_elem_q) ? i_mem_data : '0;

`ifdef LEAF_LOADER_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst || start_acc) begin
            o_cycle_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if ((run || state_q == ST_DRAIN) && o_cycle_cnt != '1)
                o_cycle_cnt <= o_cycle_cnt + 1'b1;
            if (run && !gnt_vld && o_stall_cnt != '1)
                o_stall_cnt <= o_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_leaf_loader.sv
module tb_leaf_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start4 = 1'b0, start1 = 1'b0;

    logic        busy4, done4, rd4;
    logic [3:0]  addr4;
    logic [31:0] mem4 = '0, data4;
    logic [3:0]  full4 = '0, wr4;

    logic        busy1, done1, rd1;
    logic [1:0]  addr1;
    logic [31:0] mem1 = '0, data1;
    logic [0:0]  full1 = '0, wr1;

`ifdef LEAF_LOADER_PERF_EN
    logic [31:0] ccnt4, scnt4, ccnt1, scnt1;
`endif

    leaf_loader #(.LEAF_CNT(4), .LEN_SEQ(4), .TERM_CNT(2), .DATA_WIDTH(32)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .o_busy(busy4), .o_done(done4),
        .o_mem_rd(rd4), .o_mem_addr(addr4), .i_mem_data(mem4),
        .i_fifo_full(full4), .o_fifo_write(wr4), .o_fifo_data(data4)
`ifdef LEAF_LOADER_PERF_EN
        , .o_cycle_cnt(ccnt4), .o_stall_cnt(scnt4)
`endif
    );

    leaf_loader #(.LEAF_CNT(1), .LEN_SEQ(3), .TERM_CNT(1), .DATA_WIDTH(32)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .o_busy(busy1), .o_done(done1),
        .o_mem_rd(rd1), .o_mem_addr(addr1), .i_mem_data(mem1),
        .i_fifo_full(full1), .o_fifo_write(wr1), .o_fifo_data(data1)
`ifdef LEAF_LOADER_PERF_EN
        , .o_cycle_cnt(ccnt1), .o_stall_cnt(scnt1)
`endif
    );

    // Run memory: mem[a] = a+1, one-cycle read latency.
    always @(posedge clk) begin
        if (rd4) mem4 <= 32'(addr4) + 32'd1;
        if (rd1) mem1 <= 32'(addr1) + 32'd1;
    end

    int total = 0, bad = 0;
    int cyc = 0, t0 = 0;
    int wr4_cnt, first4, done4_cnt, done4_cyc;
    int wr1_cnt, first1, last1, done1_cnt, done1_cyc;
    logic [3:0] pf4 = '0;
    bit chk_order = 1'b0, allfull_chk = 1'b0;

    logic [31:0] q4 [4][$];
    logic [31:0] q1 [$];
    int          order_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        if (wr4 != '0) begin
            int k;
            k = 0;
            for (int i = 0; i < 4; i++) if (wr4[i]) k = i;
            chk("wr4_onehot", 64'($onehot(wr4)), 1);
            chk("wr4_full_leaf", 64'(pf4[k]), 0);
            if (q4[k].size() == 0) chk("wr4_unexpected", 1, 0);
            else chk($sformatf("leaf%0d_data", k), data4, q4[k].pop_front());
            if (chk_order && order_q.size() > 0) chk("wr4_order", k, order_q.pop_front());
            if (wr4_cnt == 0) first4 = cyc - t0;
            wr4_cnt++;
        end
        if (done4) begin done4_cnt++; done4_cyc = cyc - t0; end
        if (allfull_chk && full4 == 4'hf) chk("rd_allfull", rd4, 0);
        pf4 = full4;
        if (wr1 != '0) begin
            if (q1.size() == 0) chk("wr1_unexpected", 1, 0);
            else chk("leaf_single_data", data1, q1.pop_front());
            if (wr1_cnt == 0) first1 = cyc - t0;
            else chk("wr1_gap", cyc - last1, 2);
            last1 = cyc;
            wr1_cnt++;
        end
        if (done1) begin done1_cnt++; done1_cyc = cyc - t0; end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load4();
        for (int i = 0; i < 4; i++) begin
            q4[i].delete();
            for (int e = 0; e < 4; e++) q4[i].push_back(32'(4 * i + e + 1));
            repeat (2) q4[i].push_back(32'd0);
        end
        order_q.delete();
        for (int r = 0; r < 6; r++) for (int i = 0; i < 4; i++) order_q.push_back(i);
        wr4_cnt = 0; done4_cnt = 0; first4 = -1; done4_cyc = -1;
    endtask

    task automatic go4();
        start4 = 1'b1;
        t0 = cyc;
        tick();
        start4 = 1'b0;
    endtask

    task automatic wait_done4(input int bound);
        int n;
        n = 0;
        while (done4_cnt == 0 && n < bound) begin tick(); n++; end
        chk("done4_seen", 64'(done4_cnt != 0), 1);
    endtask

    task automatic check_drained(input string tag);
        chk({tag, "_writes"}, wr4_cnt, 24);
        for (int i = 0; i < 4; i++) chk({tag, "_leftover"}, q4[i].size(), 0);
    endtask

    initial begin
        wr4_cnt = 0; first4 = -1; done4_cnt = 0; done4_cyc = -1;
        wr1_cnt = 0; first1 = -1; last1 = 0; done1_cnt = 0; done1_cyc = -1;

        // reset state
        repeat (3) tick();
        chk("rst_busy", busy4, 0);
        chk("rst_done", done4, 0);
        chk("rst_rd", rd4, 0);
        chk("rst_addr", addr4, 0);
        chk("rst_wr", wr4, 0);
        chk("rst_data", data4, 0);
        chk("rst_wr1", wr1, 0);
        rst = 1'b0;
        tick();

        // basic pass
        load4(); chk_order = 1'b1;
        go4();
        chk("busy_after_start", busy4, 1);
        wait_done4(60);
        chk("basic_first_wr", first4, 2);
        chk("basic_done_cyc", done4_cyc, 27);
        check_drained("basic");
        repeat (3) tick();
        chk("basic_single_done", done4_cnt, 1);
        chk("basic_idle", busy4, 0);
`ifdef LEAF_LOADER_PERF_EN
        chk("basic_cycle_cnt", ccnt4, 25);
        chk("basic_stall_cnt", scnt4, 0);
`endif

        // start pulse during RUN is ignored
        load4();
        go4();
        repeat (8) tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done4(60);
        repeat (5) tick();
        check_drained("ign");
        chk("ign_single_done", done4_cnt, 1);
        chk("ign_done_cyc", done4_cyc, 27);

        // backpressure on leaf 1 for 10 cycles
        load4(); chk_order = 1'b0;
        full4 = 4'b0010;
        go4();
        repeat (9) tick();
        chk("bp_progress", wr4_cnt, 8);
        full4 = '0;
        wait_done4(80);
        check_drained("bp");

        // everything full for the first 5 RUN cycles
        load4(); chk_order = 1'b1;
        full4 = 4'hf; allfull_chk = 1'b1;
        go4();
        repeat (5) tick();
        full4 = '0; allfull_chk = 1'b0;
        wait_done4(80);
        chk("af_first_wr", first4, 7);
        chk("af_done_cyc", done4_cyc, 32);
        check_drained("af");
`ifdef LEAF_LOADER_PERF_EN
        chk("af_stall_cnt", scnt4, 5);
        chk("af_cycle_cnt", ccnt4, 30);
`endif

        // single leaf: one write every other cycle
        q1.delete();
        q1.push_back(32'd1); q1.push_back(32'd2); q1.push_back(32'd3); q1.push_back(32'd0);
        wr1_cnt = 0; done1_cnt = 0;
        start1 = 1'b1;
        t0 = cyc;
        tick();
        start1 = 1'b0;
        for (int n = 0; n < 40 && done1_cnt == 0; n++) tick();
        chk("single_done_seen", 64'(done1_cnt != 0), 1);
        chk("single_first_wr", first1, 2);
        chk("single_writes", wr1_cnt, 4);
        chk("single_done_cyc", done1_cyc, 10);
        chk("single_leftover", q1.size(), 0);

        // reset in the middle of a pass
        load4(); chk_order = 1'b1;
        go4();
        for (int n = 0; n < 40 && wr4_cnt < 7; n++) tick();
        chk("mid_reached_7", wr4_cnt, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", busy4, 0);
        chk("mid_rst_wr", wr4, 0);
        @(posedge clk);
        #1;
        cyc++;
        load4();
        go4();
        wait_done4(60);
        chk("reload_first_wr", first4, 2);
        chk("reload_done_cyc", done4_cyc, 27);
        check_drained("reload");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
